bfloat16_result_fifo: RTL and testbench

- Downstream stage of the bfloat16 adder. Captures each 16-bit sum on the adder's one-cycle ready pulse and buffers it in a small FIFO.
- Presents results to the consumer over a valid/ready handshake, tagging each result with zero/special classification flags.
- Decouples the adder's fixed 3-cycle result cadence from a consumer that may stall.

---
 rtl/bfloat16_result_fifo.sv | 176 +++++++++++++++++
 tb/tb_bfloat16_result_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat16_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bfloat16_result_fifo
// Purpose  : Result buffer behind the bfloat16 adder. A sum is captured on
//            each sum_ready_in pulse and stored in a first-word-fall-through
//            FIFO. The consumer reads it over a valid/ready handshake. Each
//            head entry is tagged with zero and inf/NaN classification flags.
// Ports    : clock, nreset         - clock (rising edge), async active-low reset
//            sum_in, sum_ready_in  - adder result and its one-cycle ready pulse
//            out_data, out_valid,
//            out_ready             - consumer handshake, head entry (FWFT)
//            out_is_zero           - out_data[14:0] == 0 (sign ignored)
//            out_is_special        - exponent out_data[14:7] == 8'hFF
//            count, full           - occupancy 0..DEPTH, and count == DEPTH
//            overflow,
//            clear_overflow        - sticky drop flag and its synchronous clear
// Option   : BF16_FIFO_STATS_EN adds the push_total (16b) and drop_total (8b)
//            saturating counters. They are cleared only by nreset.
// Revision : 1.0 - initial release
// ============================================================================
module bfloat16_result_fifo #(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [15:0]       sum_in,
    input  logic              sum_ready_in,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_zero,
    output logic              out_is_special,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    input  logic              clear_overflow
`ifdef BF16_FIFO_STATS_EN
    ,
    output logic [15:0]       push_total,
    output logic [7:0]        drop_total
`endif
);

    localparam logic [ADDR_W:0]   C_FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q, overflow_d;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [15:0]       w_head;

    // ------------------------------------------------------------------
    // Handshake decode. full/empty come from the count, not from the
    // pointers. When the FIFO is full, a pop in the same cycle frees the
    // slot for the incoming push, so no result is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_empty = (count_q == '0);
        w_full  = (count_q == C_FULL_CNT);
        w_pop   = !w_empty && out_ready;
        w_push  = sum_ready_in && (!w_full || w_pop);
        w_drop  = sum_ready_in && w_full && !w_pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // DEPTH is a power of two, so the pointers wrap by plain overflow.
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // If a drop and a clear happen in the same cycle, the drop wins.
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset. The count gates every read, so stale contents
    // are never visible.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= sum_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The head is read combinationally from storage and forced
    // to zero while the FIFO is empty. There is no bypass from sum_in.
    // ------------------------------------------------------------------
    always_comb begin
        w_head = w_empty ? 16'h0000 : mem_q[rd_ptr_q];
    end

    assign out_data       = w_head;
    assign out_valid      = !w_empty;
    assign out_is_zero    = (w_head[14:0] == 15'h0000);
    assign out_is_special = (w_head[14:7] == 8'hFF);
    assign count          = count_q;
    assign full           = w_full;
    assign overflow       = overflow_q;

`ifdef BF16_FIFO_STATS_EN
    // ------------------------------------------------------------------
    // Saturating activity counters. They are cleared by reset only.
    // ------------------------------------------------------------------
    logic [15:0] push_total_q, push_total_d;
    logic [7:0]  drop_total_q, drop_total_d;

    always_comb begin
        push_total_d = push_total_q;
        drop_total_d = drop_total_q;
        if (w_push && (push_total_q != 16'hFFFF)) begin
            push_total_d = push_total_q + 16'd1;
        end
        if (w_drop && (drop_total_q != 8'hFF)) begin
            drop_total_d = drop_total_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            push_total_q <= '0;
            drop_total_q <= '0;
        end else begin
            push_total_q <= push_total_d;
            drop_total_q <= drop_total_d;
        end
    end

    assign push_total = push_total_q;
    assign drop_total = drop_total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bfloat16_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfloat16_result_fifo
// Purpose  : Self-checking bench for bfloat16_result_fifo (DEPTH = 8). A
//            queue-based reference model tracks the expected contents. The
//            outputs are compared against the model on every falling edge.
//            Directed literal checks pin down the key behaviours.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfloat16_result_fifo;

    localparam int DEPTH = 8;

    logic        clock;
    logic        nreset;
    logic [15:0] sum_in;
    logic        sum_ready_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_zero;
    logic        out_is_special;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic        clear_overflow;
`ifdef BF16_FIFO_STATS_EN
    logic [15:0] push_total;
    logic [7:0]  drop_total;
`endif

    bfloat16_result_fifo #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .nreset         (nreset),
        .sum_in         (sum_in),
        .sum_ready_in   (sum_ready_in),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_is_zero    (out_is_zero),
        .out_is_special (out_is_special),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef BF16_FIFO_STATS_EN
        ,
        .push_total     (push_total),
        .drop_total     (drop_total)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of accepted sums and a sticky drop flag
    // ------------------------------------------------------------------
    logic [15:0] mq[$];
    bit          m_ovf   = 1'b0;
    int          m_push  = 0;
    int          m_drop  = 0;
    bit          m_pop;
    bit          m_slot;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_push = 0;
            m_drop = 0;
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_slot = (mq.size() < DEPTH) || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (sum_ready_in && m_slot) begin
                mq.push_back(sum_in);
                if (m_push < 65535) m_push++;
            end
            if (sum_ready_in && !m_slot) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end else if (clear_overflow) begin
                m_ovf = 1'b0;
            end
        end
    end

    logic [15:0] exp_head;

    always @(negedge clock) begin
        if (cmp_en) begin
            exp_head = (mq.size() != 0) ? mq[0] : 16'h0000;
            chk("cmp_valid",   {31'b0, out_valid},      {31'b0, mq.size() != 0});
            chk("cmp_data",    {16'b0, out_data},       {16'b0, exp_head});
            chk("cmp_zero",    {31'b0, out_is_zero},    {31'b0, exp_head[14:0] == 15'h0});
            chk("cmp_special", {31'b0, out_is_special}, {31'b0, exp_head[14:7] == 8'hFF});
            chk("cmp_count",   {28'b0, count},          mq.size());
            chk("cmp_full",    {31'b0, full},           {31'b0, mq.size() == DEPTH});
            chk("cmp_ovf",     {31'b0, overflow},       {31'b0, m_ovf});
`ifdef BF16_FIFO_STATS_EN
            chk("cmp_push_total", {16'b0, push_total}, m_push);
            chk("cmp_drop_total", {24'b0, drop_total}, m_drop);
`endif
        end
    end

    // Drive one cycle of inputs, then step to 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic c);
        sum_ready_in   = v;
        sum_in         = d;
        out_ready      = r;
        clear_overflow = c;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 nreset = 1'b0;
        @(posedge clock);
        #3 nreset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [15:0] vals [8];
    logic [15:0] rv;

    initial begin
        nreset = 1'b0; sum_in = '0; sum_ready_in = 0; out_ready = 0; clear_overflow = 0;
        repeat (2) @(posedge clock);
        #2;
        // Reset state
        chk("rst_valid",   {31'b0, out_valid},      0);
        chk("rst_count",   {28'b0, count},          0);
        chk("rst_full",    {31'b0, full},           0);
        chk("rst_data",    {16'b0, out_data},       0);
        chk("rst_zero",    {31'b0, out_is_zero},    1);
        chk("rst_special", {31'b0, out_is_special}, 0);
        chk("rst_ovf",     {31'b0, overflow},       0);
        cmp_en = 1'b1;
        #1 nreset = 1'b1;
        @(posedge clock); #1;

        // A single push becomes visible after the edge
        cyc(1, 16'h3F80, 0, 0);
        chk("p1_valid",   {31'b0, out_valid},      1);
        chk("p1_data",    {16'b0, out_data},       32'h3F80);
        chk("p1_count",   {28'b0, count},          1);
        chk("p1_zero",    {31'b0, out_is_zero},    0);
        chk("p1_special", {31'b0, out_is_special}, 0);

        // Fill the FIFO, then overflow it
        for (int i = 0; i < 7; i++) cyc(1, 16'h1000 + 16'(i), 0, 0);
        chk("fill_full",  {31'b0, full},  1);
        chk("fill_count", {28'b0, count}, 8);
        cyc(1, 16'h4000, 0, 0);
        chk("ovf_set",   {31'b0, overflow}, 1);
        chk("ovf_count", {28'b0, count},    8);
        chk("ovf_head",  {16'b0, out_data}, 32'h3F80);
        cyc(0, 0, 0, 1);
        chk("ovf_clear", {31'b0, overflow}, 0);

        // Push and pop together while full
        cyc(1, 16'h7F80, 1, 0);
        chk("fullpp_count", {28'b0, count},    8);
        chk("fullpp_ovf",   {31'b0, overflow}, 0);
        for (int i = 0; i < 7; i++) vals[i] = 16'h1000 + 16'(i);
        vals[7] = 16'h7F80;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", {16'b0, out_data}, {16'b0, vals[i]});
            if (i == 7) chk("drain_special", {31'b0, out_is_special}, 1);
            cyc(0, 0, 1, 0);
        end
        chk("drain_count", {28'b0, count}, 0);

        // Streaming with wrap-around
        for (int i = 0; i < 20; i++) begin
            cyc(1, 16'h2000 + 16'(i * 3), 1, 0);
            chk("stream_data", {16'b0, out_data}, 32'h2000 + i * 3);
        end
        cyc(0, 0, 1, 0);
        chk("stream_count", {28'b0, count}, 0);

        // -0 is flagged as zero. Reset in the middle of the stream.
        cyc(1, 16'h8000, 0, 0);
        chk("negzero_flag", {31'b0, out_is_zero}, 1);
        for (int i = 0; i < 4; i++) cyc(1, 16'h4100 + 16'(i), 0, 0);
        chk("pre_rst_count", {28'b0, count}, 5);
        #2 nreset = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 0);
        chk("midrst_count", {28'b0, count},     0);
        chk("midrst_ovf",   {31'b0, overflow},  0);
        @(posedge clock);
        #3 nreset = 1'b1;
        @(posedge clock); #1;

`ifdef BF16_FIFO_STATS_EN
        for (int i = 0; i < 10; i++) cyc(1, 16'h3000 + 16'(i), 0, 0);
        chk("stats_push", {16'b0, push_total}, 8);
        chk("stats_drop", {24'b0, drop_total}, 2);
        cyc(0, 0, 0, 1);
        chk("stats_keep", {16'b0, push_total}, 8);
        do_reset();
`endif

        // Randomized traffic, checked by the model on every falling edge
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       rv = 16'h7F80 | 16'($urandom_range(0, 127));
                1:       rv = $urandom_range(0, 1) ? 16'h8000 : 16'h0000;
                default: rv = 16'($urandom);
            endcase
            cyc($urandom_range(0, 9) < 6, rv,
                (i % 400) < 200 ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7),
                $urandom_range(0, 19) == 0);
            if (i % 997 == 996) do_reset();
        end

        cyc(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
